// File: rtl/fetch_queue.sv
// Instruction fetch unit with a small queue between instruction memory and decode.
// Optional FETCH_PERF_CNT_EN adds fetched-instruction and stall-cycle counters.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_REQ,
        S_SQUASH,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     pc_q, pc_d;

    logic [31:0]     q_pc    [DEPTH];
    logic [31:0]     q_instr [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q, cnt_nxt;

    logic            ack, enq, deq;

    // An ack only counts against a request we are actually presenting
    assign ack = mem_ack & req_q;
    assign deq = if_valid & if_ready;
    assign enq = (state_q == S_REQ) & ack & ~redirect;

    assign cnt_nxt = cnt_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign if_valid = (cnt_q != '0);
    assign if_instr = q_instr[rd_q];
    assign if_pc    = q_pc[rd_q];

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        unique case (state_q)
            S_REQ: begin
                if (!req_q) begin
                    // first cycle out of reset: nothing outstanding yet
                    req_d = 1'b1;
                    if (redirect) begin
                        addr_d = redirect_pc;
                        pc_d   = redirect_pc;
                    end
                end else if (redirect) begin
                    if (ack) begin
                        addr_d = redirect_pc;
                        pc_d   = redirect_pc;
                    end else begin
                        state_d = S_SQUASH;
                        pc_d    = redirect_pc;
                    end
                end else if (ack) begin
                    pc_d = addr_q + 32'd4;
                    if (cnt_nxt == FULL) begin
                        state_d = S_HOLD;
                        req_d   = 1'b0;
                    end else begin
                        addr_d = addr_q + 32'd4;
                    end
                end
            end
            S_SQUASH: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (ack) begin
                    state_d = S_REQ;
                    addr_d  = redirect ? redirect_pc : pc_q;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    addr_d  = redirect_pc;
                    pc_d    = redirect_pc;
                end else if (deq || cnt_q != FULL) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (redirect) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (enq) begin
                q_pc[wr_q]    <= addr_q;
                q_instr[wr_q] <= mem_rdata;
                wr_q          <= wr_q + 1'b1;
            end
            if (deq) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (enq) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (state_q == S_HOLD) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    fetch_queue #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string name,
                                input logic [31:0] got,
                                input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [31:0] wd(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Reference model: queue contents plus the outstanding request
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    bit          m_req = 1'b0;
    logic [31:0] m_addr;
    logic [31:0] npc;
    bit          stale = 1'b0;
    bit          synced = 1'b0;

    always @(posedge clk) begin
        bit acc;
        if (reset) begin
            mq.delete();
            m_req  = 1'b0;
            m_addr = RESET_PC;
            npc    = RESET_PC;
            stale  = 1'b0;
            synced = 1'b1;
        end else if (synced) begin
            acc = mem_ack && m_req;
            if (redirect) begin
                mq.delete();
                if (m_req && !acc) begin
                    stale = 1'b1;
                    npc   = redirect_pc;
                end else begin
                    m_req  = 1'b1;
                    m_addr = redirect_pc;
                    stale  = 1'b0;
                end
            end else begin
                if (if_ready && mq.size() > 0) void'(mq.pop_front());
                if (!m_req) begin
                    if (mq.size() < DEPTH) begin
                        m_req  = 1'b1;
                        m_addr = npc;
                    end
                end else if (acc) begin
                    if (stale) begin
                        stale  = 1'b0;
                        m_addr = npc;
                    end else begin
                        mq.push_back({m_addr, mem_rdata});
                        npc = m_addr + 32'd4;
                        if (mq.size() == DEPTH) m_req = 1'b0;
                        else m_addr = npc;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (synced) begin
            chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
            if (m_req) chk("mem_addr", mem_addr, m_addr);
            chk("if_valid", {31'd0, if_valid}, {31'd0, mq.size() > 0});
            if (mq.size() > 0) begin
                chk("if_pc", if_pc, mq[0].pc);
                chk("if_instr", if_instr, mq[0].ins);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        if_ready = 1'b0;
        mem_ack  = 1'b0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] acked[$];
        logic [31:0] seen[$];
        int          ack_cyc;
        int          val_cyc;
        int          nack;

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        if_ready    = 1'b0;
        mem_ack     = 1'b1;
        mem_rdata   = '0;

        // reset state, with a spurious ack that must be ignored
        repeat (2) step();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        mem_ack = 1'b0;
        reset   = 1'b0;
        step();
        chk("rel_mem_req", {31'd0, mem_req}, 32'd1);

        // streaming: ack every cycle, decode always ready
        do_reset();
        ack_cyc = -1;
        val_cyc = -1;
        for (int k = 0; k < 10; k++) begin
            mem_ack   = mem_req;
            mem_rdata = wd(mem_addr);
            if_ready  = 1'b1;
            if (mem_req && mem_ack) begin
                acked.push_back(mem_addr);
                if (ack_cyc < 0) ack_cyc = k;
            end
            if (if_valid) begin
                seen.push_back(if_pc);
                if (val_cyc < 0) val_cyc = k;
                chk("stream_instr", if_instr, wd(if_pc));
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            chk("stream_addr", acked[i], 32'(4 * i));
            chk("stream_pc", seen[i], 32'(4 * i));
        end
        chk("latency", 32'(val_cyc), 32'(ack_cyc + 1));

        // fill with decode stalled, then release one slot
        do_reset();
        mem_ack = 1'b0;
        nack    = 0;
        for (int k = 0; k < 8; k++) begin
            mem_ack   = mem_req;
            mem_rdata = wd(mem_addr);
            if (mem_req) nack++;
            step();
        end
        mem_ack = 1'b0;
        chk("full_acks", 32'(nack), 32'd4);
        chk("full_hold", {31'd0, mem_req}, 32'd0);
        chk("full_head", if_pc, 32'h0);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        chk("rel_req", {31'd0, mem_req}, 32'd1);
        chk("rel_addr", mem_addr, 32'h10);
        chk("rel_head", if_pc, 32'h4);

        // redirect while a fetch is pending -> squash
        do_reset();
        step();
        repeat (2) begin
            mem_ack   = 1'b1;
            mem_rdata = wd(mem_addr);
            step();
        end
        mem_ack     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("sq_addr", mem_addr, 32'h8);
        chk("sq_req", {31'd0, mem_req}, 32'd1);
        chk("sq_valid", {31'd0, if_valid}, 32'd0);
        repeat (2) step();
        chk("sq_hold_addr", mem_addr, 32'h8);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        chk("sq_new_addr", mem_addr, 32'h100);
        chk("sq_dropped", {31'd0, if_valid}, 32'd0);
        mem_rdata = wd(32'h100);
        step();
        mem_ack = 1'b0;
        chk("sq_first_pc", if_pc, 32'h100);
        chk("sq_first_instr", if_instr, wd(32'h100));

        // redirect coinciding with ack and dequeue
        do_reset();
        step();
        mem_ack   = 1'b1;
        mem_rdata = wd(mem_addr);
        step();
        mem_rdata   = wd(mem_addr);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        if_ready    = 1'b1;
        step();
        redirect = 1'b0;
        if_ready = 1'b0;
        chk("rda_empty", {31'd0, if_valid}, 32'd0);
        chk("rda_addr", mem_addr, 32'h200);
        mem_rdata = wd(32'h200);
        step();
        mem_ack = 1'b0;
        chk("rda_head", if_pc, 32'h200);

        // reset with entries queued and a request pending
        do_reset();
        step();
        repeat (3) begin
            mem_ack   = 1'b1;
            mem_rdata = wd(mem_addr);
            step();
        end
        reset = 1'b1;
        step();
        chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        chk("rst_prio_addr", mem_addr, RESET_PC);
        chk("rst_prio_req", {31'd0, mem_req}, 32'd0);
        reset    = 1'b0;
        redirect = 1'b0;
        mem_ack  = 1'b0;
        step();
        chk("post_rst_addr", mem_addr, RESET_PC);

        // address wrap at the top of memory
        mem_ack     = 1'b1;
        mem_rdata   = wd(mem_addr);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect  = 1'b0;
        chk("wrap_start", mem_addr, 32'hFFFF_FFFC);
        mem_rdata = wd(mem_addr);
        step();
        mem_ack = 1'b0;
        chk("wrap_addr", mem_addr, 32'h0);
        chk("wrap_head", if_pc, 32'hFFFF_FFFC);

        // randomized traffic
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            reset       = ($urandom_range(0, 199) == 0);
            mem_ack     = mem_req && ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) mem_ack = 1'b1;
            mem_rdata   = $urandom;
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            if_ready    = ($urandom_range(0, 9) < 6);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
